// File: rtl/box_motion_sched_pkg.sv
// vga_pkg: shared VGA geometry, box sizes, scheduler state encoding and
// direction encoding for the box motion scheduler.
package vga_pkg;
    localparam logic [9:0] VGA_WIDTH  = 10'd640;
    localparam logic [9:0] VGA_HEIGHT = 10'd480;
    localparam logic [9:0] BOX0_SIZE  = 10'd200;
    localparam logic [9:0] BOX1_SIZE  = 10'd64;

    // Direction of travel along one axis.
    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    // One state per coordinate visited by the shared step unit.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0X  = 3'd1,
        B0Y  = 3'd2,
        B1X  = 3'd3,
        B1Y  = 3'd4,
        DONE = 3'd5
    } state_t;
endpackage

// File: rtl/box_motion_sched_if.sv
// Control and position bundle of box_motion_sched.
//   master: frame source / compositor side (drives vsync, speed, pause, step)
//   slave : the scheduler (drives box positions, busy, frame_done)
interface box_motion_sched_if;
    logic       vsync;
    logic [3:0] speed;
    logic       pause;
    logic       step;
    logic [9:0] box0_x;
    logic [9:0] box0_y;
    logic [9:0] box1_x;
    logic [9:0] box1_y;
    logic       busy;
    logic       frame_done;

    modport master (
        output vsync, speed, pause, step,
        input  box0_x, box0_y, box1_x, box1_y, busy, frame_done
    );
    modport slave (
        input  vsync, speed, pause, step,
        output box0_x, box0_y, box1_x, box1_y, busy, frame_done
    );
endinterface

// File: rtl/box_motion_sched_axis_step.sv
// box_axis_step: combinational bounce step for one coordinate.
//   i_pos/i_dir   current coordinate and direction
//   i_size        box edge length, i_limit screen extent on this axis
//   i_speed       pixels to move this frame
//   o_next_pos/o_next_dir  coordinate and direction after the step
module box_axis_step
    import vga_pkg::*;
(
    input  logic [9:0] i_pos,
    input  logic       i_dir,
    input  logic [9:0] i_size,
    input  logic [9:0] i_limit,
    input  logic [3:0] i_speed,
    output logic [9:0] o_next_pos,
    output logic       o_next_dir
);
    logic [10:0] w_sum;
    logic [10:0] w_lim_m1;
    logic [9:0]  w_top;
    logic [9:0]  w_inc;
    logic [9:0]  w_dec;

    // Compare at 11 bits so pos+size+speed cannot wrap.
    assign w_sum    = {1'b0, i_pos} + {1'b0, i_size} + {7'd0, i_speed};
    assign w_lim_m1 = {1'b0, i_limit} - 11'd1;
    assign w_top    = i_limit - 10'd1 - i_size;
    assign w_inc    = i_pos + {6'd0, i_speed};
    assign w_dec    = i_pos - {6'd0, i_speed};

    always_comb begin
        o_next_pos = i_pos;
        o_next_dir = i_dir;
        if (i_dir == DIR_INC) begin
            // Clamp to the far edge and bounce; with speed 0 this only
            // fires when already sitting on the edge.
            if (w_sum >= w_lim_m1) begin
                o_next_pos = w_top;
                o_next_dir = DIR_DEC;
            end else begin
                o_next_pos = w_inc;
            end
        end else begin
            if (i_pos < {6'd0, i_speed}) begin
                o_next_pos = 10'd0;
                o_next_dir = DIR_INC;
            end else begin
                o_next_pos = w_dec;
            end
        end
    end
endmodule

// File: rtl/box_motion_sched.sv
// box_motion_sched: per-frame position update for two bouncing boxes.
//   clk   pixel clock
//   reset asynchronous active-high reset
//   bus   vsync/speed/pause/step in; box positions, busy, frame_done out
// A vsync rise starts a five-state walk (B0X,B0Y,B1X,B1Y,DONE) that shares
// one box_axis_step across the four coordinates.
module box_motion_sched
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    box_motion_sched_if.slave bus
);
    state_t     r_state, w_next;
    logic       r_vsync_q;
    logic       r_step_pending;
    logic [3:0] r_speed;
    logic       r_busy;
    logic       r_frame_done;
    logic [9:0] r_b0x, r_b0y, r_b1x, r_b1y;
    logic [3:0] r_dir;          // {b1y, b1x, b0y, b0x}

    logic       w_rise;
    logic       w_start;
    logic [9:0] w_pos, w_size, w_limit, w_next_pos;
    logic       w_dir, w_next_dir;

    assign w_rise  = bus.vsync & ~r_vsync_q;
    assign w_start = w_rise && (r_state == IDLE) && (!bus.pause || r_step_pending);

    // Route the coordinate owned by the current state into the step unit.
    always_comb begin
        w_next  = IDLE;
        w_pos   = 10'd0;
        w_dir   = DIR_INC;
        w_size  = 10'd0;
        w_limit = 10'd0;
        case (r_state)
            IDLE: w_next = w_start ? B0X : IDLE;
            B0X: begin
                w_next = B0Y; w_pos = r_b0x; w_dir = r_dir[0];
                w_size = BOX0_SIZE; w_limit = VGA_WIDTH;
            end
            B0Y: begin
                w_next = B1X; w_pos = r_b0y; w_dir = r_dir[1];
                w_size = BOX0_SIZE; w_limit = VGA_HEIGHT;
            end
            B1X: begin
                w_next = B1Y; w_pos = r_b1x; w_dir = r_dir[2];
                w_size = BOX1_SIZE; w_limit = VGA_WIDTH;
            end
            B1Y: begin
                w_next = DONE; w_pos = r_b1y; w_dir = r_dir[3];
                w_size = BOX1_SIZE; w_limit = VGA_HEIGHT;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    box_axis_step u_step (
        .i_pos      (w_pos),
        .i_dir      (w_dir),
        .i_size     (w_size),
        .i_limit    (w_limit),
        .i_speed    (r_speed),
        .o_next_pos (w_next_pos),
        .o_next_dir (w_next_dir)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_vsync_q      <= 1'b0;
            r_step_pending <= 1'b0;
            r_speed        <= 4'd0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_b0x          <= 10'd0;
            r_b0y          <= 10'd0;
            r_b1x          <= 10'd0;
            r_b1y          <= VGA_HEIGHT - 10'd1 - BOX1_SIZE;
            r_dir          <= {DIR_DEC, DIR_INC, DIR_INC, DIR_INC};
        end else begin
            r_state      <= w_next;
            r_vsync_q    <= bus.vsync;
            r_busy       <= (w_next != IDLE);
            r_frame_done <= (w_next == DONE);
            if (w_start) begin
                r_speed        <= bus.speed;
                r_step_pending <= 1'b0;
            end else if (bus.step && bus.pause) begin
                r_step_pending <= 1'b1;
            end
            case (r_state)
                B0X: begin r_b0x <= w_next_pos; r_dir[0] <= w_next_dir; end
                B0Y: begin r_b0y <= w_next_pos; r_dir[1] <= w_next_dir; end
                B1X: begin r_b1x <= w_next_pos; r_dir[2] <= w_next_dir; end
                B1Y: begin r_b1y <= w_next_pos; r_dir[3] <= w_next_dir; end
                default: ;
            endcase
        end
    end

    assign bus.box0_x     = r_b0x;
    assign bus.box0_y     = r_b0y;
    assign bus.box1_x     = r_b1x;
    assign bus.box1_y     = r_b1y;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_box_motion_sched.sv
module tb_box_motion_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    box_motion_sched_if bus();

    box_motion_sched dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { int x0; int y0; int x1; int y1; } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_pos[4];
    int   m_dir[4];
    bit   m_pend;

    function automatic void mstep(input int size, input int limit, input int spd,
                                  inout int pos, inout int dir);
        if (dir == 0) begin
            if (pos + size + spd >= limit - 1) begin pos = limit - 1 - size; dir = 1; end
            else pos = pos + spd;
        end else begin
            if (pos < spd) begin pos = 0; dir = 0; end
            else pos = pos - spd;
        end
    endfunction

    function automatic void push_expected(input int spd);
        exp_t e;
        mstep(200, 640, spd, m_pos[0], m_dir[0]);
        mstep(200, 480, spd, m_pos[1], m_dir[1]);
        mstep(64,  640, spd, m_pos[2], m_dir[2]);
        mstep(64,  480, spd, m_pos[3], m_dir[3]);
        e.x0 = m_pos[0]; e.y0 = m_pos[1]; e.x1 = m_pos[2]; e.y1 = m_pos[3];
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every frame_done pulse consumes one expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (bus.frame_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_done_unexpected: got pulse, required none");
            end else begin
                e = exp_q.pop_front();
                if (bus.box0_x !== 10'(e.x0) || bus.box0_y !== 10'(e.y0) ||
                    bus.box1_x !== 10'(e.x1) || bus.box1_y !== 10'(e.y1)) begin
                    errors++;
                    $display("FAIL frame_pos: got (%0d,%0d)(%0d,%0d) required (%0d,%0d)(%0d,%0d)",
                             bus.box0_x, bus.box0_y, bus.box1_x, bus.box1_y,
                             e.x0, e.y0, e.x1, e.y1);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.vsync = 1'b0; bus.step = 1'b0; bus.pause = 1'b0; bus.speed = 4'd0;
        m_pos = '{0, 0, 0, 415};
        m_dir = '{0, 0, 0, 1};
        m_pend = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One vsync pulse; the sequence (if any) finishes well inside the pulse.
    task automatic frame(input int spd);
        @(negedge clk);
        bus.speed = 4'(spd);
        bus.vsync = 1'b1;
        if (!bus.pause || m_pend) begin
            push_expected(spd);
            m_pend = 1'b0;
        end
        repeat (8) @(negedge clk);
        bus.vsync = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_missing: got %0d pending frames, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.box0_x !== 10'd0 || bus.box0_y !== 10'd0 || bus.box1_x !== 10'd0 ||
            bus.box1_y !== 10'd415 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got (%0d,%0d)(%0d,%0d) busy=%b fd=%b required (0,0)(0,415) 0 0",
                     bus.box0_x, bus.box0_y, bus.box1_x, bus.box1_y, bus.busy, bus.frame_done);
        end
    endtask

    task automatic test_first_frame_timing();
        logic exp_busy[6] = '{1, 1, 1, 1, 1, 0};
        logic exp_fd[6]   = '{0, 0, 0, 0, 1, 0};
        int   exp_b0x[6]  = '{0, 5, 5, 5, 5, 5};
        do_reset();
        @(negedge clk);
        bus.speed = 4'd5;
        bus.vsync = 1'b1;
        push_expected(5);
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== exp_busy[e] || bus.frame_done !== exp_fd[e] ||
                bus.box0_x !== 10'(exp_b0x[e])) begin
                errors++;
                $display("FAIL first_frame_cycle%0d: got busy=%b fd=%b x0=%0d required busy=%b fd=%b x0=%0d",
                         e + 1, bus.busy, bus.frame_done, bus.box0_x,
                         exp_busy[e], exp_fd[e], exp_b0x[e]);
            end
        end
        bus.vsync = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.box0_x !== 10'd5 || bus.box0_y !== 10'd5 || bus.box1_x !== 10'd5 || bus.box1_y !== 10'd410) begin
            errors++;
            $display("FAIL first_frame_pos: got (%0d,%0d)(%0d,%0d) required (5,5)(5,410)",
                     bus.box0_x, bus.box0_y, bus.box1_x, bus.box1_y);
        end
    endtask

    task automatic test_box0_bounce();
        do_reset();
        for (int f = 1; f <= 89; f++) begin
            frame(5);
            if (f == 56) begin
                checks++;
                if (bus.box0_y !== 10'd279) begin
                    errors++; $display("FAIL box0_y_edge: got %0d required 279", bus.box0_y);
                end
            end
            if (f == 88) begin
                checks++;
                if (bus.box0_x !== 10'd439) begin
                    errors++; $display("FAIL box0_x_edge: got %0d required 439", bus.box0_x);
                end
            end
        end
        checks++;
        if (bus.box0_x !== 10'd434) begin
            errors++; $display("FAIL box0_x_return: got %0d required 434", bus.box0_x);
        end
    endtask

    task automatic test_box1_top();
        do_reset();
        for (int f = 1; f <= 29; f++) begin
            frame(15);
            if (f == 27 || f == 28) begin
                checks++;
                if (bus.box1_y !== ((f == 27) ? 10'd10 : 10'd0)) begin
                    errors++;
                    $display("FAIL box1_y_frame%0d: got %0d required %0d", f, bus.box1_y, (f == 27) ? 10 : 0);
                end
            end
        end
        checks++;
        if (bus.box1_y !== 10'd15) begin
            errors++; $display("FAIL box1_y_after_flip: got %0d required 15", bus.box1_y);
        end
    endtask

    task automatic test_speed_zero();
        do_reset();
        frame(0);
        checks++;
        if (bus.box0_x !== 10'd0 || bus.box1_y !== 10'd415) begin
            errors++; $display("FAIL speed_zero: got x0=%0d y1=%0d required 0 415", bus.box0_x, bus.box1_y);
        end
    endtask

    task automatic test_pause_step();
        do_reset();
        frame(5);
        // step while running is ignored, so the paused frame after it is suppressed
        @(negedge clk); bus.step = 1'b1; @(negedge clk); bus.step = 1'b0;
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) frame(5);
        checks++;
        if (bus.box0_x !== 10'd5 || bus.box1_y !== 10'd410) begin
            errors++; $display("FAIL paused_hold: got x0=%0d y1=%0d required 5 410", bus.box0_x, bus.box1_y);
        end
        @(negedge clk); bus.step = 1'b1; m_pend = 1'b1; @(negedge clk); bus.step = 1'b0;
        frame(5);
        checks++;
        if (bus.box0_x !== 10'd10 || bus.box1_y !== 10'd405) begin
            errors++; $display("FAIL step_once: got x0=%0d y1=%0d required 10 405", bus.box0_x, bus.box1_y);
        end
        frame(5);
        checks++;
        if (bus.box0_x !== 10'd10) begin
            errors++; $display("FAIL step_cleared: got x0=%0d required 10", bus.box0_x);
        end
        bus.pause = 1'b0;
    endtask

    task automatic test_reset_mid_sequence();
        do_reset();
        frame(5);
        @(negedge clk);
        bus.speed = 4'd5;
        bus.vsync = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.box0_x !== 10'd0 || bus.box0_y !== 10'd0 || bus.box1_x !== 10'd0 ||
            bus.box1_y !== 10'd415 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_seq: got (%0d,%0d)(%0d,%0d) busy=%b required (0,0)(0,415) 0",
                     bus.box0_x, bus.box0_y, bus.box1_x, bus.box1_y, bus.busy);
        end
        bus.vsync = 1'b0;
        do_reset();
        frame(5);
        checks++;
        if (bus.box0_x !== 10'd5 || bus.box1_y !== 10'd410) begin
            errors++; $display("FAIL after_reset_frame: got x0=%0d y1=%0d required 5 410", bus.box0_x, bus.box1_y);
        end
    endtask

    task automatic test_speed_latch();
        do_reset();
        @(negedge clk);
        bus.speed = 4'd5;
        bus.vsync = 1'b1;
        push_expected(5);
        repeat (2) @(negedge clk);
        bus.speed = 4'd9;
        repeat (6) @(negedge clk);
        bus.vsync = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.box1_x !== 10'd5 || bus.box1_y !== 10'd410) begin
            errors++;
            $display("FAIL speed_latch: got x1=%0d y1=%0d pending=%0d required 5 410 0",
                     bus.box1_x, bus.box1_y, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.vsync = 1'b0; bus.step = 1'b0; bus.pause = 1'b0; bus.speed = 4'd0;
        test_reset();
        test_first_frame_timing();
        test_box0_bounce();
        test_box1_top();
        test_speed_zero();
        test_pause_step();
        test_reset_mid_sequence();
        test_speed_latch();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/box_motion_sched.md
# box_motion_sched

Frame-rate motion scheduler for two bouncing boxes on the 640x480 VGA overlay. On each vsync rising edge it runs a fixed five-state sequence that time-multiplexes one shared axis-step unit across four coordinates (box0 x/y, box1 x/y) and commits new positions and directions. It runs entirely in the pixel-clock domain, replacing vsync-clocked position registers, and feeds the pixel compositor that draws the boxes. Pause and single-step controls come from `ui_in`.

## Interface
- `VGA_WIDTH`, 640: horizontal active pixels.
- `VGA_HEIGHT`, 480: vertical active lines.
- `BOX0_SIZE`, 200: box0 edge length in pixels.
- `BOX1_SIZE`, 64: box1 edge length in pixels.
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  vsync from `hvsync_generator`; its rising edge marks a frame.
- `speed`  in  4  pixels per frame per axis; latched at sequence start.
- `pause`  in  1  level; suppresses frame updates while high.
- `step`  in  1  single-cycle pulse; requests one update while paused.
- `box0_x`, `box0_y`, `box1_x`, `box1_y`  out  10 each  top-left corner coordinates, registered.
- `busy`  out  1  high while the sequence is in progress.
- `frame_done`  out  1  single-cycle pulse when a sequence completes.

## Operation
- Edge detect: the block registers `vsync` into `vsync_q`. `rise = vsync & ~vsync_q`.
- Start condition: `rise` in IDLE, and either `pause`=0 or `step_pending`=1.
  - `step` while `pause`=1 sets `step_pending`.
  - Starting a sequence clears `step_pending`.
  - `step` while `pause`=0 is ignored.
- FSM states: IDLE -> B0X -> B0Y -> B1X -> B1Y -> DONE -> IDLE, one cycle each, with no stalls.
  - Each Bxx state drives the shared step unit with that coordinate's pos, dir, size, limit and latched speed.
  - The result and new direction are registered at the end of that state.
  - DONE asserts `frame_done`.
- Step rule, with dir 0 = increasing and limit = `VGA_WIDTH` or `VGA_HEIGHT`:
  - dir 0: if pos+size+speed >= limit-1, then pos <= limit-1-size and dir <= 1. Otherwise pos <= pos+speed.
  - dir 1: if pos < speed, then pos <= 0 and dir <= 0. Otherwise pos <= pos-speed.
- Arithmetic is evaluated at 11 bits, zero-extended, so no sum wraps. Results always fit in 10 bits.
- `speed`=0: positions hold and directions are unchanged, except that dir 0 flips when pos already equals limit-1-size.
- Any `rise` while `busy` is ignored. A sequence is 5 cycles and a frame is far longer.
- Reset values:
  - box0 = (0,0), dirs (0,0).
  - box1 = (0, `VGA_HEIGHT`-1-`BOX1_SIZE`) = (0,415), dirs (0,1).
  - `step_pending`=0, `vsync_q`=0, state IDLE.
  - `busy`=0, `frame_done`=0.
- Reset mid-sequence returns everything to its reset value immediately; partial updates are discarded.

## Timing
- Cycle 0: the first `clk` edge that sees `vsync` high after low, which registers the rise.
- Cycle 1: in B0X; `busy`=1.
- Cycle 2: `box0_x` updated.
- Cycle 3: `box0_y` updated.
- Cycle 4: `box1_x` updated.
- Cycle 5: `box1_y` updated; state DONE, `frame_done`=1.
- Cycle 6: back in IDLE; `busy`=0.
- All outputs come straight from registers. Positions are stable for the whole active video region.

## Structure
- Package `vga_pkg` holds:
  - VGA geometry constants (640, 480);
  - the state enum (IDLE, B0X, B0Y, B1X, B1Y, DONE);
  - the direction encoding.
- Sub-module `box_axis_step` is purely combinational. It maps pos, dir, size, limit, speed to next_pos and next_dir, and is instantiated once.
- The top level holds the FSM, edge detector, step latch and coordinate registers.

## Test plan
- Reset then one rise, `speed`=5, `pause`=0 -> box0=(5,5), box1=(5,410), `frame_done` pulse at cycle 5, `busy` high cycles 1-5.
- 88 frames at `speed`=5 -> box0_x=439 with dx=1. After 56 frames, box0_y=279 with dy=1.
- box1 with `speed`=15 from reset -> y reaches 0 and dy flips to 0 on frame 28 (415-15*27=10, and 10<15).
- `pause`=1, 3 rises -> no change. Then `step` pulse and one rise -> exactly one update, `step_pending` cleared; a further rise -> no change.
- `reset` asserted at cycle 3 of a sequence -> all outputs at reset values the same cycle. The next rise behaves as the first frame.
- `speed` changed from 5 to 9 at cycle 2 -> the current sequence still uses 5 on all four coordinates.
